// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: drives iCE40 PLL RESETB, qualifies the synchronized LOCK and releases the downstream reset
module pll_lock_reset_seq #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int STABLE_CYCLES       = 1024,
  parameter int SYNC_STAGES         = 2,
  parameter int CNT_W               = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             lock_i,
  output logic             pll_resetb_o,
  output logic             rst_o,
  output logic             ready_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retries_o,
  output logic [CNT_W-1:0] lost_o,
  output logic [1:0]       state_o
);
  localparam int MAX_A = RESET_CYCLES > LOCK_TIMEOUT_CYCLES ? RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_C = MAX_A > STABLE_CYCLES ? MAX_A : STABLE_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic lock_s, timeout_n;
  logic [CNT_W-1:0] retries_n, lost_n;
  assign lock_s       = sync[SYNC_STAGES-1];
  assign pll_resetb_o = state != PLL_RST;
  assign rst_o        = state != RUN;
  assign ready_o      = state == RUN;
  assign state_o      = state;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state     <= PLL_RST;
      cnt       <= '0;
      sync      <= '0;
      timeout_o <= 1'b0;
      retries_o <= '0;
      lost_o    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sync      <= {sync[SYNC_STAGES-2:0], lock_i};
      timeout_o <= timeout_n;
      retries_o <= retries_n;
      lost_o    <= lost_n;
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    timeout_n = timeout_o;
    retries_n = retries_o;
    lost_n    = lost_o;
    case (state)
      PLL_RST:
        if (cnt == CW'(RESET_CYCLES - 1)) state_n = WAIT_LOCK;
      WAIT_LOCK:
        if (lock_s) state_n = STABLE;
        else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_n   = PLL_RST;
          timeout_n = 1'b1;
          retries_n = &retries_o ? retries_o : retries_o + 1'b1;
        end
      STABLE:
        if (!lock_s) state_n = WAIT_LOCK;
        else if (cnt == CW'(STABLE_CYCLES - 1)) state_n = RUN;
      RUN: begin
        cnt_n = cnt;
        if (!lock_s) begin
          state_n = PLL_RST;
          lost_n  = &lost_o ? lost_o : lost_o + 1'b1;
        end
      end
    endcase
    if (state_n != state) cnt_n = '0;
  end
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: directed checks of the PLL reset sequencer with small timing parameters
module tb_pll_lock_reset_seq;
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  logic lock_i = 1'b0;
  logic pll_resetb_o, rst_o, ready_o, timeout_o;
  logic [7:0] retries_o, lost_o;
  logic [1:0] state_o;
  int n_checks = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  pll_lock_reset_seq #(
    .RESET_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32), .STABLE_CYCLES(8), .SYNC_STAGES(2), .CNT_W(8)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .lock_i(lock_i), .pll_resetb_o(pll_resetb_o),
    .rst_o(rst_o), .ready_o(ready_o), .timeout_o(timeout_o), .retries_o(retries_o),
    .lost_o(lost_o), .state_o(state_o)
  );
  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
    int i = 0;
    while (state_o !== s && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'(state_o), 32'(s));
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_rst"}, 32'(rst_o), 1);
    chk({tag, "_resetb"}, 32'(pll_resetb_o), 0);
    chk({tag, "_flags"}, {timeout_o, retries_o, lost_o}, 0);
  endtask
  initial begin
    // 1: reset and PLL reset pulse width
    tick(3);
    chk_cleared("reset");
    chk("reset_ready", 32'(ready_o), 0);
    reset_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rstb_low", 32'(pll_resetb_o), 0);
      tick();
    end
    chk("rstb_high", 32'(pll_resetb_o), 1);
    chk("enter_wait", 32'(state_o), 1);
    // 2: lock after 10 cycles of waiting, release 11 cycles after the edge
    tick(10);
    lock_i = 1'b1;
    tick(2);
    chk("sync_delay", 32'(state_o), 1);
    tick();
    chk("enter_stable", 32'(state_o), 2);
    tick(7);
    chk("rst_before", 32'(rst_o), 1);
    tick();
    chk("rst_release", 32'(rst_o), 0);
    chk("ready", 32'(ready_o), 1);
    chk("run_state", 32'(state_o), 3);
    chk("no_retry", {timeout_o, retries_o}, 0);
    // 5: lock loss in RUN
    lock_i = 1'b0;
    tick(2);
    chk("loss_sync", 32'(rst_o), 0);
    tick();
    chk("loss_rst", 32'(rst_o), 1);
    chk("loss_resetb", 32'(pll_resetb_o), 0);
    chk("lost_cnt", 32'(lost_o), 1);
    lock_i = 1'b1;
    wait_state("relock_run", 2'd3, 40);
    chk("relock_lost", 32'(lost_o), 1);
    // 6: reset during RUN
    reset_ni = 1'b0;
    tick();
    chk_cleared("rst_in_run");
    reset_ni = 1'b1;
    wait_state("to_stable", 2'd2, 20);
    // 4: single-cycle lock dropout at stable counter 5
    tick(3);
    lock_i = 1'b0;
    tick();
    lock_i = 1'b1;
    tick(2);
    chk("glitch_wait", 32'(state_o), 1);
    chk("glitch_rst", 32'(rst_o), 1);
    tick();
    chk("glitch_restable", 32'(state_o), 2);
    tick(7);
    chk("fresh_8_pending", 32'(state_o), 2);
    chk("fresh_rst", 32'(rst_o), 1);
    tick();
    chk("fresh_run", 32'(state_o), 3);
    // 6: reset during STABLE
    lock_i = 1'b0;
    tick(3);
    chk("loss_again", 32'(lost_o), 1);
    lock_i = 1'b1;
    wait_state("stable_again", 2'd2, 20);
    reset_ni = 1'b0;
    tick();
    chk_cleared("rst_in_stable");
    // 3: timeouts and retry saturation
    lock_i = 1'b0;
    reset_ni = 1'b1;
    tick(35);
    chk("pre_timeout_state", 32'(state_o), 1);
    chk("pre_timeout_flag", 32'(timeout_o), 0);
    tick();
    chk("timeout_state", 32'(state_o), 0);
    chk("timeout_flag", 32'(timeout_o), 1);
    chk("retries_1", 32'(retries_o), 1);
    tick(36);
    chk("retries_2", 32'(retries_o), 2);
    tick(36 * 253);
    chk("retries_255", 32'(retries_o), 255);
    tick(36 * 3);
    chk("retries_sat", 32'(retries_o), 255);
    chk("timeout_sticky", 32'(timeout_o), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pll_lock_reset_seq.md
Name: pll_lock_reset_seq

Overview:
Reset sequencer for the iCE40 PLL pad primitive.
- Runs on the free-running board reference clock, i.e. the same pad clock that feeds the PLL.
- Drives the PLL RESETB pin and synchronizes the asynchronous LOCK output.
- Releases the downstream image-pipeline reset only after lock has been stable for a qualified interval.
- Handles lock timeout and lock loss by re-resetting the PLL. rst_o is re-synchronized into the PLL clock domain by the consumer.

Parameters:
RESET_CYCLES, 16, cycles pll_resetb_o is held low per PLL reset attempt (>=1)
LOCK_TIMEOUT_CYCLES, 4096, cycles to wait for lock before retrying (>=2)
STABLE_CYCLES, 1024, consecutive locked cycles required before release (>=1)
SYNC_STAGES, 2, flops in lock_i synchronizer (>=2)
CNT_W, 8, width of retry and lock-loss counters

Ports:
clk_i  input  1  free-running reference clock
reset_ni  input  1  synchronous active-low reset
lock_i  input  1  PLL LOCK, asynchronous to clk_i
pll_resetb_o  output  1  to PLL RESETB, active-low
rst_o  output  1  active-high reset for downstream logic
ready_o  output  1  high while in RUN
timeout_o  output  1  sticky: at least one lock timeout occurred
retries_o  output  CNT_W  lock-timeout retry count, saturating
lost_o  output  CNT_W  lock-loss-in-RUN count, saturating
state_o  output  2  PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3

Behaviour:
Reset, sync, counter
- Reset: on any posedge with reset_ni=0: state=PLL_RST, counter=0, sync chain=0, timeout_o=0, retries_o=0, lost_o=0. Reset overrides all other events.
- Mid-operation reset from any state behaves identically.
- lock_s is the last stage of a SYNC_STAGES-flop chain on lock_i. The FSM only ever uses lock_s.
- One shared counter, width $clog2(max(RESET_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)+1). Cleared on every state transition.

Outputs
- All outputs are Moore decodes of registered state and counters; no combinational path from lock_i.
- pll_resetb_o = (state != PLL_RST)
- rst_o = (state != RUN)
- ready_o = (state == RUN)
- Reset values: pll_resetb_o=0, rst_o=1, ready_o=0, timeout_o=0, retries_o=0, lost_o=0, state_o=0.

FSM transitions
- PLL_RST: counter++. At counter==RESET_CYCLES-1 -> WAIT_LOCK. pll_resetb_o is low for exactly RESET_CYCLES cycles.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Else at counter==LOCK_TIMEOUT_CYCLES-1 -> PLL_RST; timeout_o<=1; retries_o++ (saturate at all-ones).
  - Else counter++.
  - If lock_s rises on the timeout cycle, lock wins: go to STABLE, no retry counted.
- STABLE:
  - lock_s=0 -> WAIT_LOCK. The timeout window restarts; no retry counted.
  - Else at counter==STABLE_CYCLES-1 -> RUN.
  - Else counter++.
  - Lock must be high for STABLE_CYCLES consecutive sampled cycles.
- RUN: lock_s=0 -> PLL_RST; lost_o++ (saturating). Otherwise hold.

Latency
- lock_i rise to rst_o fall, with lock held: SYNC_STAGES + STABLE_CYCLES + 1 cycles.
- lock_i fall in RUN to rst_o rise: SYNC_STAGES + 1 cycles.
- Glitches shorter than one clk_i period may be missed; glitches that are sampled follow the rules above.

Test Plan:
All scenarios use overrides RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, STABLE_CYCLES=8, SYNC_STAGES=2, CNT_W=8.
1. Reset held low 3 cycles, lock_i=0 -> rst_o=1, pll_resetb_o=0, state_o=0. After release, pll_resetb_o low for exactly 4 cycles, then state_o=1.
2. lock_i rises 10 cycles after entering WAIT_LOCK and stays high -> state_o=2 after 2 sync cycles. rst_o falls and ready_o=1 exactly 11 cycles after the lock_i edge. retries_o=0, timeout_o=0.
3. lock_i held 0 -> after 32 cycles in WAIT_LOCK, state_o=0 and timeout_o=1. retries_o increments every 36 cycles. Forcing retries_o to 255 and continuing: retries_o stays 255.
4. In STABLE, lock_i drops 1 cycle at counter=5 -> returns to WAIT_LOCK, rst_o stays 1. Relocking requires a full 8 fresh cycles.
5. In RUN, lock_i drops -> rst_o=1 and pll_resetb_o=0 three cycles later; lost_o=1. Relocking yields RUN again.
6. reset_ni pulsed low during RUN and during STABLE -> next cycle state_o=0, rst_o=1, all counters and flags 0.
